// File: rtl/a_chan_merge_pkg.sv
// Shared types and constants for the three-channel merger.
package a_chan_merge_pkg;

   typedef logic [1:0] chan_t;

   localparam chan_t CH0 = 2'd0;
   localparam chan_t CH1 = 2'd1;
   localparam chan_t CH2 = 2'd2;

   localparam int unsigned MODE_RR   = 0;
   localparam int unsigned MODE_PRIO = 1;

   function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                        input int unsigned c);
      int unsigned m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/a_chan_fifo.sv
// Synchronous FIFO with extra-MSB pointers; a pop frees a slot for a same-cycle push.
module a_chan_fifo #(
   parameter int unsigned g_width = 8,
   parameter int unsigned g_depth = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               push,
   input  logic [g_width-1:0] din,
   input  logic               pop,
   output logic [g_width-1:0] rd_data_c,
   output logic               full_c,
   output logic               empty_c
);

   localparam int unsigned AW = $clog2(g_depth);

   logic [AW:0]        wr_ptr;
   logic [AW:0]        rd_ptr;
   logic [g_width-1:0] mem [g_depth];
   logic               do_push;
   logic               do_pop;

   assign empty_c   = (wr_ptr == rd_ptr);
   assign full_c    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign do_pop    = pop && !empty_c;
   assign do_push   = push && (!full_c || do_pop);
   assign rd_data_c = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
         if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
      end
   end

   // Storage is not reset; pointers alone define what is valid.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= din;
   end

endmodule

// File: rtl/a_chan_merge.sv
// Three-channel merger: per-channel FIFOs, arbiter, and an elastic output pipeline.
module a_chan_merge
   import a_chan_merge_pkg::*;
#(
   parameter int unsigned g_w1    = 8,
   parameter int unsigned g_w2    = 32,
   parameter int unsigned g_w3    = 16,
   parameter int unsigned g_depth = 4,
   parameter int unsigned g_delay = 2,
   parameter int unsigned g_mode  = MODE_RR,
   localparam int unsigned WMAX   = max3(g_w1, g_w2 + 2, g_w3 * 2)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [g_w1-1:0]       d1,
   input  logic                  d1_valid,
   input  logic [g_w2+1:0]       d2,
   input  logic                  d2_valid,
   input  logic [2*g_w3-1:0]     d3,
   input  logic                  d3_valid,
   output logic [WMAX-1:0]       out_data,
   output logic [1:0]            out_chan,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [2:0]            ovf,
   input  logic [2:0]            clr_ovf
);

   localparam int unsigned W2 = g_w2 + 2;
   localparam int unsigned W3 = g_w3 * 2;

   logic [g_w1-1:0]    f0_data;
   logic [W2-1:0]      f1_data;
   logic [W3-1:0]      f2_data;
   logic [2:0]         push;
   logic [2:0]         full;
   logic [2:0]         empty;
   logic [2:0]         grant;
   logic [2:0]         drop;
   logic               grant_any;
   chan_t              grant_chan;
   chan_t              idx;
   chan_t              rr_ptr;
   logic [WMAX-1:0]    arb_data;

   logic [g_delay-1:0] st_valid;
   logic [g_delay-1:0] st_load;
   logic [g_delay-1:0] in_valid;
   logic [WMAX-1:0]    st_data [g_delay];
   logic [WMAX-1:0]    in_data [g_delay];
   chan_t              st_chan [g_delay];
   chan_t              in_chan [g_delay];

   assign push = {d3_valid, d2_valid, d1_valid};
   assign drop = push & full & ~grant;

   a_chan_fifo #(.g_width(g_w1), .g_depth(g_depth)) u_fifo0 (
      .clk(clk), .rst_n(rst_n), .push(push[0]), .din(d1), .pop(grant[0]),
      .rd_data_c(f0_data), .full_c(full[0]), .empty_c(empty[0]));

   a_chan_fifo #(.g_width(W2), .g_depth(g_depth)) u_fifo1 (
      .clk(clk), .rst_n(rst_n), .push(push[1]), .din(d2), .pop(grant[1]),
      .rd_data_c(f1_data), .full_c(full[1]), .empty_c(empty[1]));

   a_chan_fifo #(.g_width(W3), .g_depth(g_depth)) u_fifo2 (
      .clk(clk), .rst_n(rst_n), .push(push[2]), .din(d3), .pop(grant[2]),
      .rd_data_c(f2_data), .full_c(full[2]), .empty_c(empty[2]));

   // A stage may load when it, or any stage downstream of it, will be vacated.
   always_comb begin : stage_ctrl
      logic run;
      run     = out_ready;
      st_load = '0;
      for (int k = int'(g_delay) - 1; k >= 0; k--) begin
         run        = run | ~st_valid[k];
         st_load[k] = run;
      end
   end

   // Arbiter: rr_ptr is the first channel searched in round-robin mode.
   always_comb begin
      grant      = '0;
      grant_any  = 1'b0;
      grant_chan = CH0;
      idx        = CH0;
      if (st_load[0]) begin
         for (int i = 0; i < 3; i++) begin
            if (g_mode == MODE_PRIO) idx = chan_t'(i);
            else                     idx = chan_t'((int'(rr_ptr) + i) % 3);
            if (!grant_any && !empty[idx]) begin
               grant[idx] = 1'b1;
               grant_any  = 1'b1;
               grant_chan = idx;
            end
         end
      end
   end

   always_comb begin
      arb_data = '0;
      case (grant_chan)
         CH1:     arb_data = WMAX'(f1_data);
         CH2:     arb_data = WMAX'(f2_data);
         default: arb_data = WMAX'(f0_data);
      endcase
   end

   always_comb begin
      in_valid[0] = grant_any;
      in_data[0]  = arb_data;
      in_chan[0]  = grant_chan;
      for (int k = 1; k < int'(g_delay); k++) begin
         in_valid[k] = st_valid[k-1];
         in_data[k]  = st_data[k-1];
         in_chan[k]  = st_chan[k-1];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st_valid <= '0;
         for (int k = 0; k < int'(g_delay); k++) begin
            st_data[k] <= '0;
            st_chan[k] <= CH0;
         end
      end else begin
         for (int k = 0; k < int'(g_delay); k++) begin
            if (st_load[k]) begin
               st_valid[k] <= in_valid[k];
               if (in_valid[k]) begin
                  st_data[k] <= in_data[k];
                  st_chan[k] <= in_chan[k];
               end
            end
         end
      end
   end

   // A same-cycle drop wins over the clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr <= CH0;
         ovf    <= '0;
      end else begin
         ovf <= (ovf & ~clr_ovf) | drop;
         if (grant_any) rr_ptr <= (grant_chan == CH2) ? CH0 : grant_chan + 2'd1;
      end
   end

   assign out_valid = st_valid[g_delay-1];
   assign out_data  = st_data[g_delay-1];
   assign out_chan  = st_chan[g_delay-1];

endmodule

// File: tb/tb_a_chan_merge.sv
// Self-checking bench for a_chan_merge: round-robin and priority instances share stimulus.
module tb_a_chan_merge;

   localparam int unsigned W1    = 8;
   localparam int unsigned W2    = 32;
   localparam int unsigned W3    = 16;
   localparam int unsigned DEPTH = 4;
   localparam int unsigned DELAY = 2;
   localparam int unsigned WMAX  = 34;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [W1-1:0]     d1;
   logic              d1_valid;
   logic [W2+1:0]     d2;
   logic              d2_valid;
   logic [2*W3-1:0]   d3;
   logic              d3_valid;
   logic              out_ready;
   logic [2:0]        clr_ovf;

   logic [WMAX-1:0]   rr_data, pr_data;
   logic [1:0]        rr_chan, pr_chan;
   logic              rr_valid, pr_valid;
   logic [2:0]        rr_ovf, pr_ovf;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   a_chan_merge #(.g_w1(W1), .g_w2(W2), .g_w3(W3), .g_depth(DEPTH), .g_delay(DELAY),
                  .g_mode(0)) dut_rr (
      .clk(clk), .rst_n(rst_n), .d1(d1), .d1_valid(d1_valid), .d2(d2), .d2_valid(d2_valid),
      .d3(d3), .d3_valid(d3_valid), .out_data(rr_data), .out_chan(rr_chan),
      .out_valid(rr_valid), .out_ready(out_ready), .ovf(rr_ovf), .clr_ovf(clr_ovf));

   a_chan_merge #(.g_w1(W1), .g_w2(W2), .g_w3(W3), .g_depth(DEPTH), .g_delay(DELAY),
                  .g_mode(1)) dut_prio (
      .clk(clk), .rst_n(rst_n), .d1(d1), .d1_valid(d1_valid), .d2(d2), .d2_valid(d2_valid),
      .d3(d3), .d3_valid(d3_valid), .out_data(pr_data), .out_chan(pr_chan),
      .out_valid(pr_valid), .out_ready(out_ready), .ovf(pr_ovf), .clr_ovf(clr_ovf));

   task automatic idle();
      d1_valid = 1'b0;
      d2_valid = 1'b0;
      d3_valid = 1'b0;
      clr_ovf  = '0;
   endtask

   task automatic apply_reset();
      idle();
      out_ready = 1'b0;
      rst_n     = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_reset();
      logic [WMAX-1:0] exp_d;
      logic [WMAX-1:0] got_d;
      logic [1:0]      got_c;
      int first, cnt;
      apply_reset();
      n_checks++;
      if ({rr_valid, rr_data, rr_chan, rr_ovf} !== '0) begin
         n_fail++;
         $display("FAIL reset_state: valid=%b data=%h chan=%0d ovf=%b, required all zero",
                  rr_valid, rr_data, rr_chan, rr_ovf);
      end
      // Build up traffic and an overflow, then reset in the middle of it.
      out_ready = 1'b0;
      for (int i = 0; i < 10; i++) begin
         d3 = $urandom; d3_valid = 1'b1;
         @(negedge clk);
      end
      idle();
      n_checks++;
      if (rr_valid !== 1'b1 || rr_ovf !== 3'b100) begin
         n_fail++;
         $display("FAIL reset_pre_traffic: valid=%b ovf=%b, required 1 and 100", rr_valid, rr_ovf);
      end
      #2 rst_n = 1'b0;
      #1;
      n_checks++;
      if ({rr_valid, rr_ovf, pr_valid, pr_ovf} !== 8'h00) begin
         n_fail++;
         $display("FAIL reset_async: rr valid=%b ovf=%b prio valid=%b ovf=%b, required 0",
                  rr_valid, rr_ovf, pr_valid, pr_ovf);
      end
      @(negedge clk);
      rst_n     = 1'b1;
      out_ready = 1'b1;
      d1 = 8'($urandom); d1_valid = 1'b1; exp_d = WMAX'(d1);
      first = -1; cnt = 0; got_d = '0; got_c = '0;
      for (int i = 1; i <= 10; i++) begin
         @(negedge clk);
         idle();
         if (rr_valid === 1'b1) begin
            if (first < 0) begin first = i; got_d = rr_data; got_c = rr_chan; end
            cnt++;
         end
      end
      n_checks++;
      if (first != int'(DELAY) + 1 || cnt != 1) begin
         n_fail++;
         $display("FAIL reset_first_push: latency=%0d words=%0d, required %0d and 1",
                  first, cnt, DELAY + 1);
      end
      n_checks++;
      if (got_d !== exp_d || got_c !== 2'd0) begin
         n_fail++;
         $display("FAIL reset_first_data: data=%h chan=%0d, required %h chan 0", got_d, got_c, exp_d);
      end
   endtask

   task automatic test_single();
      logic [WMAX-1:0] got_d;
      logic [1:0]      got_c;
      int first, cnt;
      apply_reset();
      out_ready = 1'b1;
      d1 = 8'hA5; d1_valid = 1'b1;
      first = -1; cnt = 0; got_d = '0; got_c = '1;
      for (int i = 1; i <= 8; i++) begin
         @(negedge clk);
         idle();
         if (rr_valid === 1'b1) begin
            if (first < 0) begin first = i; got_d = rr_data; got_c = rr_chan; end
            cnt++;
         end
      end
      n_checks++;
      if (first != int'(DELAY) + 1) begin
         n_fail++;
         $display("FAIL single_latency: got %0d cycles, required %0d", first, DELAY + 1);
      end
      n_checks++;
      if (cnt != 1) begin
         n_fail++;
         $display("FAIL single_valid_width: valid for %0d cycles, required 1", cnt);
      end
      n_checks++;
      if (got_d !== 34'h0_0000_00A5 || got_c !== 2'd0) begin
         n_fail++;
         $display("FAIL single_data: data=%h chan=%0d, required 00000000a5 chan 0", got_d, got_c);
      end
   endtask

   task automatic test_arbitration();
      logic [WMAX-1:0] q_rr [3][$];
      logic [WMAX-1:0] q_pr [3][$];
      int exp_rr[$], exp_pr[$];
      int cnt[3];
      int ptr, ch, n_rr, n_pr, f_rr, l_rr, f_pr, l_pr;
      apply_reset();
      out_ready = 1'b1;
      for (int w = 0; w < 2; w++) begin
         d1 = 8'($urandom); d2 = {2'($urandom), 32'($urandom)}; d3 = $urandom;
         d1_valid = 1'b1; d2_valid = 1'b1; d3_valid = 1'b1;
         q_rr[0].push_back(WMAX'(d1)); q_rr[1].push_back(WMAX'(d2)); q_rr[2].push_back(WMAX'(d3));
         q_pr[0].push_back(WMAX'(d1)); q_pr[1].push_back(WMAX'(d2)); q_pr[2].push_back(WMAX'(d3));
         @(negedge clk);
      end
      idle();
      // Expected grant order from the arbitration rules alone.
      cnt = '{2, 2, 2}; ptr = 0;
      repeat (6) begin
         for (int i = 0; i < 3; i++) begin
            ch = (ptr + i) % 3;
            if (cnt[ch] > 0) begin exp_rr.push_back(ch); cnt[ch]--; ptr = (ch + 1) % 3; break; end
         end
      end
      cnt = '{2, 2, 2};
      repeat (6) begin
         for (int i = 0; i < 3; i++) begin
            if (cnt[i] > 0) begin exp_pr.push_back(i); cnt[i]--; break; end
         end
      end
      n_rr = 0; n_pr = 0; f_rr = -1; l_rr = -1; f_pr = -1; l_pr = -1;
      for (int i = 0; i < 14; i++) begin
         if (rr_valid === 1'b1) begin
            if (n_rr < 6) begin
               ch = exp_rr[n_rr];
               n_checks++;
               if (rr_chan !== 2'(ch) || rr_data !== q_rr[ch][0]) begin
                  n_fail++;
                  $display("FAIL rr_order[%0d]: chan=%0d data=%h, required chan %0d data %h",
                           n_rr, rr_chan, rr_data, ch, q_rr[ch][0]);
               end
               void'(q_rr[ch].pop_front());
            end
            if (f_rr < 0) f_rr = i;
            l_rr = i; n_rr++;
         end
         if (pr_valid === 1'b1) begin
            if (n_pr < 6) begin
               ch = exp_pr[n_pr];
               n_checks++;
               if (pr_chan !== 2'(ch) || pr_data !== q_pr[ch][0]) begin
                  n_fail++;
                  $display("FAIL prio_order[%0d]: chan=%0d data=%h, required chan %0d data %h",
                           n_pr, pr_chan, pr_data, ch, q_pr[ch][0]);
               end
               void'(q_pr[ch].pop_front());
            end
            if (f_pr < 0) f_pr = i;
            l_pr = i; n_pr++;
         end
         @(negedge clk);
      end
      n_checks++;
      if (n_rr != 6 || l_rr - f_rr != 5) begin
         n_fail++;
         $display("FAIL rr_back_to_back: words=%0d span=%0d, required 6 words over 6 cycles",
                  n_rr, l_rr - f_rr + 1);
      end
      n_checks++;
      if (n_pr != 6 || l_pr - f_pr != 5) begin
         n_fail++;
         $display("FAIL prio_back_to_back: words=%0d span=%0d, required 6 words over 6 cycles",
                  n_pr, l_pr - f_pr + 1);
      end
   endtask

   task automatic test_overflow();
      logic [WMAX-1:0] kept[$];
      logic [2:0] exp_ovf;
      int n_out;
      apply_reset();
      out_ready = 1'b0;
      // With the output stalled a lone channel holds DEPTH words in its FIFO plus
      // DELAY words already moved into the output pipeline.
      for (int i = 0; i < int'(DEPTH + DELAY) + 2; i++) begin
         d3 = $urandom; d3_valid = 1'b1;
         clr_ovf = (i == int'(DEPTH + DELAY) + 1) ? 3'b100 : 3'b000;
         if (i < int'(DEPTH + DELAY)) kept.push_back(WMAX'(d3));
         @(negedge clk);
         exp_ovf = (i >= int'(DEPTH + DELAY)) ? 3'b100 : 3'b000;
         n_checks++;
         if (rr_ovf !== exp_ovf || pr_ovf !== exp_ovf) begin
            n_fail++;
            $display("FAIL ovf_after_push[%0d]: rr=%b prio=%b, required %b", i, rr_ovf, pr_ovf, exp_ovf);
         end
      end
      idle();
      clr_ovf = 3'b100;
      @(negedge clk);
      clr_ovf = 3'b000;
      n_checks++;
      if (rr_ovf !== 3'b000 || pr_ovf !== 3'b000) begin
         n_fail++;
         $display("FAIL ovf_clear: rr=%b prio=%b, required 000", rr_ovf, pr_ovf);
      end
      out_ready = 1'b1;
      n_out = 0;
      for (int i = 0; i < 14; i++) begin
         if (rr_valid === 1'b1) begin
            n_checks++;
            if (kept.size() == 0 || rr_chan !== 2'd2 || rr_data !== kept[0]) begin
               n_fail++;
               $display("FAIL ovf_drain[%0d]: chan=%0d data=%h, required chan 2 data %h",
                        n_out, rr_chan, rr_data, (kept.size() > 0) ? kept[0] : '0);
            end
            if (kept.size() > 0) void'(kept.pop_front());
            n_out++;
         end
         @(negedge clk);
      end
      n_checks++;
      if (n_out != int'(DEPTH + DELAY)) begin
         n_fail++;
         $display("FAIL ovf_drain_count: got %0d words, required %0d", n_out, DEPTH + DELAY);
      end
   endtask

   task automatic test_backpressure();
      logic [WMAX-1:0] sq [3][$];
      logic [WMAX-1:0] hold_d;
      logic [1:0]      hold_c;
      logic            stalled;
      int outstanding, received, sent, cycles, ch;
      apply_reset();
      outstanding = 0; received = 0; sent = 0; cycles = 0; stalled = 1'b0;
      hold_d = '0; hold_c = '0;
      while (received < 100 && cycles < 5000) begin
         if (stalled) begin
            n_checks++;
            if (rr_valid !== 1'b1 || rr_data !== hold_d || rr_chan !== hold_c) begin
               n_fail++;
               $display("FAIL bp_stable: valid=%b chan=%0d data=%h, required 1 chan %0d data %h",
                        rr_valid, rr_chan, rr_data, hold_c, hold_d);
            end
         end
         idle();
         out_ready = 1'($urandom_range(0, 1));
         if (rr_valid === 1'b1 && out_ready) begin
            n_checks++;
            if (rr_chan === 2'd3 || $isunknown(rr_chan) || sq[rr_chan].size() == 0 ||
                rr_data !== sq[rr_chan][0]) begin
               n_fail++;
               $display("FAIL bp_word[%0d]: chan=%0d data=%h, not the next word queued on that channel",
                        received, rr_chan, rr_data);
            end else begin
               void'(sq[rr_chan].pop_front());
            end
            received++;
            outstanding--;
         end
         stalled = (rr_valid === 1'b1) && !out_ready;
         hold_d  = rr_data;
         hold_c  = rr_chan;
         // Keeping fewer than DEPTH words in flight means no FIFO can be full.
         if (sent < 100 && outstanding < int'(DEPTH) && $urandom_range(0, 3) != 0) begin
            ch = $urandom_range(0, 2);
            case (ch)
               0: begin d1 = 8'($urandom); d1_valid = 1'b1; sq[0].push_back(WMAX'(d1)); end
               1: begin d2 = {2'($urandom), 32'($urandom)}; d2_valid = 1'b1; sq[1].push_back(WMAX'(d2)); end
               default: begin d3 = $urandom; d3_valid = 1'b1; sq[2].push_back(WMAX'(d3)); end
            endcase
            sent++;
            outstanding++;
         end
         @(negedge clk);
         cycles++;
      end
      idle();
      n_checks++;
      if (received != 100) begin
         n_fail++;
         $display("FAIL bp_count: received %0d words in %0d cycles, required 100", received, cycles);
      end
      out_ready = 1'b1;
      repeat (6) @(negedge clk);
      n_checks++;
      if (rr_valid !== 1'b0 || sq[0].size() + sq[1].size() + sq[2].size() != 0 || rr_ovf !== 3'b000) begin
         n_fail++;
         $display("FAIL bp_final: valid=%b pending=%0d ovf=%b, required 0, 0, 000",
                  rr_valid, sq[0].size() + sq[1].size() + sq[2].size(), rr_ovf);
      end
   endtask

   initial begin
      rst_n = 1'b0;
      out_ready = 1'b0;
      d1 = '0; d2 = '0; d3 = '0;
      idle();
      test_reset();
      test_single();
      test_arbitration();
      test_overflow();
      test_backpressure();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete within time limit");
      $fatal(1);
   end

endmodule
